input_conditioner_2ch: RTL and testbench

//   Two-channel input conditioner for raw board-level signals (switches/buttons).
//   - Per channel: synchronises the asynchronous input, then debounces it.
//   - Emits a clean level plus one-cycle rise/fall pulses.
//   - Sits directly upstream of the two-input dataflow logic stage.
//   - Clean levels drive that stage's in1/in2.

---
 rtl/input_conditioner_2ch_pkg.sv | 19 +
 rtl/input_conditioner_2ch_debounce_channel.sv | 74 +++++++
 rtl/input_conditioner_2ch.sv | 48 ++++
 tb/tb_input_conditioner_2ch.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_2ch_pkg.sv
// Shared constants for the two-channel input conditioner: default debounce
// window, synchroniser depth and the counter-width helper.
`ifndef CONDITIONER_DEFS_VH
`define CONDITIONER_DEFS_VH
`define COND_DEFAULT_DEBOUNCE 16
`define COND_SYNC_DEPTH 2
`endif

package input_conditioner_2ch_pkg;

    localparam int DEFAULT_DEBOUNCE = `COND_DEFAULT_DEBOUNCE;
    localparam int SYNC_DEPTH       = `COND_SYNC_DEPTH;

    // One spare bit above $clog2 so the terminal count always fits.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/input_conditioner_2ch_debounce_channel.sv
// One conditioner channel: two-flop synchroniser, persistence counter and
// registered one-cycle rise/fall pulses.
module debounce_channel
    import input_conditioner_2ch_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int   CNT_W           = cnt_width(DEBOUNCE_CYCLES),
    parameter logic INIT_LEVEL      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_DEPTH-1:0] r_sync;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_clean;
    logic                  r_rise;
    logic                  r_fall;
    logic                  w_synced;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_DEPTH; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) r_sync[0] <= INIT_LEVEL;
                    else        r_sync[0] <= raw;
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) r_sync[gi] <= INIT_LEVEL;
                    else        r_sync[gi] <= r_sync[gi-1];
                end
            end
        end
    endgenerate

    assign w_synced = r_sync[SYNC_DEPTH-1];

    // The count only ever advances while the synced level disagrees with the
    // accepted one, so it is cleared by either agreement or acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_clean <= INIT_LEVEL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_synced == r_clean) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_clean <= w_synced;
                r_rise  <= w_synced;
                r_fall  <= ~w_synced;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign clean = r_clean;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule

// File: rtl/input_conditioner_2ch.sv
// Two independent debounce channels feeding the downstream in1/in2 stage.
module input_conditioner_2ch
    import input_conditioner_2ch_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter logic INIT_LEVEL      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in1,
    input  logic raw_in2,
    output logic in1_clean,
    output logic in2_clean,
    output logic in1_rise,
    output logic in1_fall,
    output logic in2_rise,
    output logic in2_fall
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .INIT_LEVEL      (INIT_LEVEL)
    ) u_ch1 (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw_in1),
        .clean (in1_clean),
        .rise  (in1_rise),
        .fall  (in1_fall)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .INIT_LEVEL      (INIT_LEVEL)
    ) u_ch2 (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw_in2),
        .clean (in2_clean),
        .rise  (in2_rise),
        .fall  (in2_fall)
    );

endmodule

// File: tb/tb_input_conditioner_2ch.sv
// Self-checking bench: directed vector table, hand-written corner sequences
// and a randomized run against a sample-window reference model.
module tb_input_conditioner_2ch;

    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic raw_in1, raw_in2;
    logic in1_clean, in2_clean, in1_rise, in1_fall, in2_rise, in2_fall;
    logic [5:0] out6;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    input_conditioner_2ch #(
        .DEBOUNCE_CYCLES (DC),
        .INIT_LEVEL      (1'b0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_in1   (raw_in1),
        .raw_in2   (raw_in2),
        .in1_clean (in1_clean),
        .in2_clean (in2_clean),
        .in1_rise  (in1_rise),
        .in1_fall  (in1_fall),
        .in2_rise  (in2_rise),
        .in2_fall  (in2_fall)
    );

    assign out6 = {in1_clean, in1_rise, in1_fall, in2_clean, in2_rise, in2_fall};

    // Reference model: raw samples reach the debouncer two edges late; a
    // level is accepted once the last DC samples seen all disagree with it.
    bit dly  [2][$];
    bit hist [2][$];
    bit mclean [2];
    bit mrise  [2];
    bit mfall  [2];

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            dly[c].delete();
            dly[c].push_back(1'b0);
            dly[c].push_back(1'b0);
            hist[c].delete();
            mclean[c] = 1'b0;
            mrise[c]  = 1'b0;
            mfall[c]  = 1'b0;
        end
    endtask

    task automatic model_edge(input bit a, input bit b);
        bit seen;
        bit all_differ;
        for (int c = 0; c < 2; c++) begin
            seen = dly[c].pop_front();
            dly[c].push_back(c == 0 ? a : b);
            mrise[c] = 1'b0;
            mfall[c] = 1'b0;
            hist[c].push_back(seen);
            if (hist[c].size() > DC) void'(hist[c].pop_front());
            all_differ = (hist[c].size() == DC);
            foreach (hist[c][j]) if (hist[c][j] == mclean[c]) all_differ = 1'b0;
            if (all_differ) begin
                mclean[c] = seen;
                mrise[c]  = seen;
                mfall[c]  = !seen;
                hist[c].delete();
            end
        end
    endtask

    function automatic logic [5:0] model_vec();
        return {mclean[0], mrise[0], mfall[0], mclean[1], mrise[1], mfall[1]};
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b (c1 r1 f1 c2 r2 f2)", name, act, exp);
    endtask

    task automatic tick(input logic a, input logic b);
        raw_in1 = a;
        raw_in2 = b;
        @(posedge clk);
        model_edge(a, b);
        @(negedge clk);
    endtask

    task automatic do_reset();
        raw_in1 = 1'b0;
        raw_in2 = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic       r1;
        logic       r2;
        logic [5:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic a, input logic b, input logic [5:0] e, input int n);
        vec_t v;
        v.r1 = a; v.r2 = b; v.exp = e;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    initial begin
        logic [5:0] e;
        logic       b1, b2;
        logic [5:0] bounce;

        // Step up/down on ch1, glitch then accepted pulse on ch2.
        add(1, 0, 6'b000000, 5);
        add(1, 0, 6'b110000, 1);
        add(1, 0, 6'b100000, 3);
        add(0, 0, 6'b100000, 5);
        add(0, 0, 6'b001000, 1);
        add(0, 0, 6'b000000, 1);
        add(0, 1, 6'b000000, 3);
        add(0, 0, 6'b000000, 6);
        add(0, 1, 6'b000000, 5);
        add(0, 1, 6'b000110, 1);
        add(0, 1, 6'b000100, 2);
        add(0, 0, 6'b000100, 5);
        add(0, 0, 6'b000001, 1);
        add(0, 0, 6'b000000, 2);

        // Reset with raw inputs high.
        rst_n   = 1'b0;
        raw_in1 = 1'b1;
        raw_in2 = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_hold", out6, 6'b000000);
        rst_n = 1'b1;
        model_reset();
        tick(1, 1);
        check("reset_first_edge", out6, 6'b000000);

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].r1, tbl[i].r2);
            check($sformatf("vec%0d", i), out6, tbl[i].exp);
        end

        // Bounce 1,0,1,1,0,1 then hold: single rise 5 edges after the last 1.
        do_reset();
        bounce = 6'b101101;
        for (int t = 0; t < 16; t++) begin
            tick(t < 6 ? bounce[5-t] : 1'b1, 1'b0);
            e = (t < 10) ? 6'b000000 : (t == 10) ? 6'b110000 : 6'b100000;
            check($sformatf("bounce_t%0d", t), out6, e);
        end

        // Simultaneous opposite edges on both channels.
        do_reset();
        repeat (8) tick(1, 0);
        check("simul_pre", out6, 6'b100000);
        for (int t = 0; t < 8; t++) begin
            tick(0, 1);
            e = (t < 5) ? 6'b100000 : (t == 5) ? 6'b001110 : 6'b000100;
            check($sformatf("simul_t%0d", t), out6, e);
        end

        // Reset mid-count discards the partial window.
        do_reset();
        tick(1, 0);
        tick(1, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midcnt_in_reset", out6, 6'b000000);
        rst_n = 1'b1;
        model_reset();
        for (int t = 0; t < 8; t++) begin
            tick(1, 0);
            e = (t < 5) ? 6'b000000 : (t == 5) ? 6'b110000 : 6'b100000;
            check($sformatf("midcnt_t%0d", t), out6, e);
        end

        // Randomized run against the model, with occasional resets.
        do_reset();
        b1 = 1'b0;
        b2 = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                b1 = 1'b0;
                b2 = 1'b0;
            end
            if ($urandom_range(0, 5) == 0) b1 = ~b1;
            if ($urandom_range(0, 5) == 0) b2 = ~b2;
            tick(b1, b2);
            check($sformatf("rand%0d", n), out6, model_vec());
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
